// File: rtl/sprite_blit_scheduler.sv
// Frame render scheduler: clears the back buffer, then blits up to N_OBJ sprites
// in priority order through the single sprite ROM port, swapping buffers on frame_start.
module sprite_blit_scheduler #(
  parameter int N_OBJ = 4,
  parameter int ADDR_W = 18,
  parameter int PIX_W = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter logic [PIX_W-1:0] BG_INDEX = '0,
  parameter logic [PIX_W-1:0] TRANSPARENT = '1
) (
  input  logic                    Clk50,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic [N_OBJ-1:0]        obj_valid,
  input  logic [N_OBJ*10-1:0]     obj_x,
  input  logic [N_OBJ*10-1:0]     obj_y,
  input  logic [N_OBJ*8-1:0]      obj_w,
  input  logic [N_OBJ*8-1:0]      obj_h,
  input  logic [N_OBJ*ADDR_W-1:0] obj_base,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [PIX_W-1:0]        rom_data,
  output logic                    fb_we,
  output logic [9:0]              fb_x,
  output logic [9:0]              fb_y,
  output logic [PIX_W-1:0]        fb_data,
  output logic                    buffer_select,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic [2:0]              state_dbg_o
);
  localparam int IDX_W = $clog2(N_OBJ + 1);
  localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [10:0] X_LIM  = 11'(H_ACTIVE);
  localparam logic [10:0] Y_LIM  = 11'(V_ACTIVE);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SELECT, S_BLIT, S_DRAIN, S_WAIT} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          obj_i_q, obj_i_d;
  logic [7:0]                px_q, px_d, py_q, py_d;
  logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
  logic                      fb_we_q, fb_we_d;
  logic [9:0]                fb_x_q, fb_x_d, fb_y_q, fb_y_d;
  logic [PIX_W-1:0]          fb_data_q, fb_data_d;
  logic                      wr_q, wr_d, inb_q, inb_d;
  logic                      buf_q, buf_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic [N_OBJ-1:0]          sv_q, sv_d;
  logic [N_OBJ*10-1:0]       sx_q, sx_d, sy_q, sy_d;
  logic [N_OBJ*8-1:0]        sw_q, sw_d, sh_q, sh_d;
  logic [N_OBJ*ADDR_W-1:0]   sb_q, sb_d;

  logic                      cur_v;
  logic [9:0]                cur_x, cur_y;
  logic [7:0]                cur_w, cur_h;
  logic [ADDR_W-1:0]         cur_base;
  logic [10:0]               sum_x, sum_y;

  always_comb begin
    cur_v    = 1'b0;
    cur_x    = '0;
    cur_y    = '0;
    cur_w    = '0;
    cur_h    = '0;
    cur_base = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      if (obj_i_q == IDX_W'(k)) begin
        cur_v    = sv_q[k];
        cur_x    = sx_q[10*k +: 10];
        cur_y    = sy_q[10*k +: 10];
        cur_w    = sw_q[8*k +: 8];
        cur_h    = sh_q[8*k +: 8];
        cur_base = sb_q[ADDR_W*k +: ADDR_W];
      end
    end
    sum_x = {1'b0, cur_x} + {3'b0, px_q};
    sum_y = {1'b0, cur_y} + {3'b0, py_q};
  end

  always_comb begin
    state_d    = state_q;
    obj_i_d    = obj_i_q;
    px_d       = px_q;
    py_d       = py_q;
    rom_addr_d = rom_addr_q;
    fb_we_d    = 1'b0;
    fb_x_d     = fb_x_q;
    fb_y_d     = fb_y_q;
    fb_data_d  = fb_data_q;
    wr_d       = 1'b0;
    inb_d      = inb_q;
    buf_d      = buf_q;
    done_d     = 1'b0;
    ovr_d      = 1'b0;
    sv_d       = sv_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    sw_d       = sw_q;
    sh_d       = sh_q;
    sb_d       = sb_q;
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (frame_start) begin
          // The first clear write is set up here so (0,0) lands the cycle after frame_start.
          state_d   = S_CLEAR;
          obj_i_d   = '0;
          fb_we_d   = 1'b1;
          fb_x_d    = '0;
          fb_y_d    = '0;
          fb_data_d = BG_INDEX;
          sv_d      = obj_valid;
          sx_d      = obj_x;
          sy_d      = obj_y;
          sw_d      = obj_w;
          sh_d      = obj_h;
          sb_d      = obj_base;
          if (state_q == S_WAIT) buf_d = ~buf_q;
        end
      end
      S_CLEAR: begin
        ovr_d = frame_start;
        if (fb_x_q == X_LAST && fb_y_q == Y_LAST) begin
          state_d = S_SELECT;
        end else begin
          fb_we_d   = 1'b1;
          fb_data_d = BG_INDEX;
          if (fb_x_q == X_LAST) begin
            fb_x_d = '0;
            fb_y_d = fb_y_q + 10'd1;
          end else begin
            fb_x_d = fb_x_q + 10'd1;
          end
        end
      end
      S_SELECT: begin
        ovr_d = frame_start;
        if (obj_i_q == IDX_W'(N_OBJ)) begin
          state_d = S_WAIT;
          done_d  = 1'b1;
        end else if (cur_v && cur_w != 8'd0 && cur_h != 8'd0) begin
          state_d    = S_BLIT;
          px_d       = '0;
          py_d       = '0;
          rom_addr_d = cur_base;
        end else begin
          obj_i_d = obj_i_q + IDX_W'(1);
        end
      end
      S_BLIT: begin
        ovr_d  = frame_start;
        wr_d   = 1'b1;
        fb_x_d = sum_x[9:0];
        fb_y_d = sum_y[9:0];
        inb_d  = (sum_x < X_LIM) && (sum_y < Y_LIM);
        if (px_q == cur_w - 8'd1) begin
          px_d = '0;
          if (py_q == cur_h - 8'd1) begin
            state_d = S_DRAIN;
          end else begin
            py_d       = py_q + 8'd1;
            rom_addr_d = rom_addr_q + ADDR_W'(1);
          end
        end else begin
          px_d       = px_q + 8'd1;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        ovr_d   = frame_start;
        obj_i_d = obj_i_q + IDX_W'(1);
        state_d = S_SELECT;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR) || (state_d == S_SELECT) ||
             (state_d == S_BLIT)  || (state_d == S_DRAIN);
  end

  always_ff @(posedge Clk50) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      obj_i_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      rom_addr_q <= '0;
      fb_we_q    <= 1'b0;
      fb_x_q     <= '0;
      fb_y_q     <= '0;
      fb_data_q  <= '0;
      wr_q       <= 1'b0;
      inb_q      <= 1'b0;
      buf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      sv_q       <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      sw_q       <= '0;
      sh_q       <= '0;
      sb_q       <= '0;
    end else begin
      state_q    <= state_d;
      obj_i_q    <= obj_i_d;
      px_q       <= px_d;
      py_q       <= py_d;
      rom_addr_q <= rom_addr_d;
      fb_we_q    <= fb_we_d;
      fb_x_q     <= fb_x_d;
      fb_y_q     <= fb_y_d;
      fb_data_q  <= fb_data_d;
      wr_q       <= wr_d;
      inb_q      <= inb_d;
      buf_q      <= buf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      sv_q       <= sv_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sw_q       <= sw_d;
      sh_q       <= sh_d;
      sb_q       <= sb_d;
    end
  end

  // The ROM already registers its data, so a blit write only qualifies it against transparency.
  assign fb_we         = fb_we_q | (wr_q & inb_q & (rom_data != TRANSPARENT));
  assign fb_data       = wr_q ? rom_data : fb_data_q;
  assign fb_x          = fb_x_q;
  assign fb_y          = fb_y_q;
  assign rom_addr      = rom_addr_q;
  assign buffer_select = buf_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign overrun       = ovr_q;
  assign state_dbg_o   = state_q;
endmodule

// File: doc/sprite_blit_scheduler.md
# sprite_blit_scheduler

Renders one complete frame into the back half of `frame_buffer` per display frame. It sequences a background clear, then shares the single `spriteROM` read port among up to N_OBJ sprite requesters (runner, cloud, score digits, …) in fixed priority order. It swaps `buffer_select` only on a frame boundary after the render has finished. It replaces free-running write counters as the sole driver of the frame buffer's write side and of the ROM address.

## Interface
- N_OBJ, 4: number of sprite requesters; index 0 drawn first (bottom), N_OBJ-1 last (top)
- ADDR_W, 18: sprite ROM address width
- PIX_W, 4: palette index width
- H_ACTIVE, 640: visible columns
- V_ACTIVE, 480: visible rows
- BG_INDEX, 0: palette index written during clear
- TRANSPARENT, 4'hF: ROM index that suppresses the write

Ports:
- Clk50  in  1  system clock; all logic on posedge
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse per display frame (vsync, already in Clk50 domain)
- obj_valid  in  N_OBJ  requester wants to be drawn this frame
- obj_x, obj_y  in  N_OBJ*10  top-left screen position, packed, object i at [10i+9:10i]
- obj_w, obj_h  in  N_OBJ*8  sprite size in pixels
- obj_base  in  N_OBJ*ADDR_W  sprite start address in ROM (row-major, w per row)
- rom_addr  out  ADDR_W  spriteROM read_address
- rom_data  in  PIX_W  spriteROM data_Out, valid 1 cycle after rom_addr
- fb_we  out  1  frame buffer write enable
- fb_x, fb_y  out  10  write coordinates
- fb_data  out  PIX_W  write index
- buffer_select  out  1  front/back select to frame_buffer
- busy  out  1  render in progress
- frame_done  out  1  one-cycle pulse when render completes
- overrun  out  1  one-cycle pulse: frame_start arrived while busy

## Operation
- States: IDLE, CLEAR, SELECT, BLIT, DRAIN, WAIT.
- IDLE (after reset): on frame_start, snapshot all obj_* inputs into internal registers, set obj index = 0, go to CLEAR. No swap.
- CLEAR: write BG_INDEX to every (x,y), x fastest, 0..H_ACTIVE-1, y 0..V_ACTIVE-1. One write per cycle. After (H_ACTIVE-1, V_ACTIVE-1), go to SELECT.
- SELECT (1 cycle): if snapshot valid[i] and w≠0 and h≠0, load px=py=0 and addr=base[i], then go to BLIT. Otherwise increment i. When i passes N_OBJ-1, go to WAIT and pulse frame_done.
- BLIT: issue rom_addr=addr each cycle. addr increments by 1 with no multiplier. px advances 0..w-1, then wraps to 0 with py+1. After the last pixel (w-1, h-1), go to DRAIN.
- DRAIN (1 cycle): completes the final write, then i+1 and back to SELECT.
- Write stage, one cycle after each issue:
  - Set fb_x = x+px and fb_y = y+py. Sums are 11-bit.
  - fb_data = rom_data.
  - fb_we = 1 only if rom_data≠TRANSPARENT, sum_x<H_ACTIVE and sum_y<V_ACTIVE. Clipped or transparent pixels still consume their cycle and address.
- WAIT: on frame_start, toggle buffer_select, snapshot inputs and go to CLEAR.
- frame_start in CLEAR/SELECT/BLIT/DRAIN: pulse overrun and ignore it. There is no swap and the render continues. The swap happens at the first frame_start seen in WAIT.
- busy = 1 in CLEAR, SELECT, BLIT, DRAIN.
- Later objects overwrite earlier ones at overlapping pixels.
- Reset mid-render aborts at once:
  - state returns to IDLE
  - buffer_select = 0
  - fb_we, busy, frame_done and overrun all 0
  - rom_addr = 0
  - fb_x, fb_y and fb_data = 0

## Timing
- All outputs are registered. Reset values: all zero, buffer_select 0, state IDLE.
- frame_start at cycle t gives the first CLEAR write (fb_we=1, 0,0) at t+1.
- ROM latency is 1 cycle. The write for a pixel issued at cycle c appears at c+1.
- Per object: 1 (SELECT) + w·h (BLIT) + 1 (DRAIN) cycles. A skipped object costs 1 cycle.
- Total render = H_ACTIVE·V_ACTIVE + Σ(w·h+2) + (skipped) + 1 cycles. At 640×480 the clear takes 6.14 ms, inside a 16.7 ms frame.
- No ROM address is issued during CLEAR. rom_addr holds its last value.

## Test plan
- H_ACTIVE=16, V_ACTIVE=8, no valid objects. Pulse frame_start → 128 writes of BG_INDEX in raster order, then frame_done 1 cycle after the last SELECT. buffer_select stays 0. The second frame_start toggles it to 1.
- One object at (2,3), w=3, h=2, base=100, ROM holding idx=addr[3:0] → rom_addr 100..105 consecutive. Writes land at (2..4,3),(2..4,4) with data 4,5,6,7,8,9.
- Same sprite with base chosen so one pixel reads 4'hF → that pixel gets no fb_we and the remaining five are written.
- Object at (14,6), w=4, h=4 → only (14..15,6..7) written. The block still spends 16 BLIT cycles, and addresses advance for clipped pixels.
- Objects 0 and 1 overlap at (5,5) → the last write to (5,5) carries object 1's data.
- frame_start mid-BLIT → overrun pulse, no toggle, render completes. Reset asserted during CLEAR → next cycle all outputs 0 and state IDLE.
